// File: rtl/h264dequant_pkg.sv
// Shared types and constant tables for the H.264 streaming inverse quantiser.
package h264dequant_pkg;

  typedef enum logic [1:0] {
    MODE_AC  = 2'd0,
    MODE_LDC = 2'd1,
    MODE_CDC = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    CLS_A = 2'd0,
    CLS_B = 2'd1,
    CLS_C = 2'd2
  } pos_class_e;

  localparam int unsigned QP_MAX = 51;
  localparam logic [4:0] BLK_LEN_4X4 = 5'd16;
  localparam logic [4:0] BLK_LEN_CDC = 5'd4;

  // Dequant scale per qmod, columns are position classes A, B, C.
  localparam logic [4:0] V_TABLE [6][3] = '{
    '{5'd10, 5'd16, 5'd13},
    '{5'd11, 5'd18, 5'd14},
    '{5'd13, 5'd20, 5'd16},
    '{5'd14, 5'd23, 5'd18},
    '{5'd16, 5'd25, 5'd20},
    '{5'd18, 5'd29, 5'd23}
  };

  // Position class of each zigzag index in frame scan order.
  localparam pos_class_e ZZ_CLASS [16] = '{
    CLS_A, CLS_C, CLS_C, CLS_A, CLS_B, CLS_A, CLS_C, CLS_C,
    CLS_C, CLS_C, CLS_B, CLS_A, CLS_B, CLS_C, CLS_C, CLS_B
  };

endpackage

// File: rtl/h264dequant_qp_lut.sv
// QP split into qdiv/qmod with clamping, plus the three class scales for that qmod.
module h264dequant_qp_lut
  import h264dequant_pkg::*;
(
  input  logic [5:0] qp,
  output logic [3:0] qdiv,
  output logic [2:0] qmod,
  output logic [4:0] va,
  output logic [4:0] vb,
  output logic [4:0] vc
);

  logic [5:0] qp_c;

  always_comb begin
    qp_c = (qp > 6'(QP_MAX)) ? 6'(QP_MAX) : qp;
    qdiv = 4'(qp_c / 6'd6);
    qmod = 3'(qp_c % 6'd6);
    va   = V_TABLE[qmod][0];
    vb   = V_TABLE[qmod][1];
    vc   = V_TABLE[qmod][2];
  end

endmodule

// File: rtl/h264dequantise_stream.sv
// Streaming H.264 inverse quantiser: block tracking, 3-stage scale/shift pipeline,
// DC rounding and saturation, with a single global stall for back-pressure.
module h264dequantise_stream
  import h264dequant_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter int unsigned OW          = 16,
  parameter int unsigned LASTADVANCE = 0,
  parameter int unsigned SATURATE    = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 IN_SOP,
  input  logic [5:0]           QP,
  input  logic [1:0]           MODE,
  input  logic signed [DW-1:0] ZIN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OUT_LAST,
  output logic                 OUT_DC,
  output logic signed [OW-1:0] WOUT,
  output logic                 ERR
);

  localparam int unsigned PW = DW + 6;
  localparam int unsigned SW = PW + 8;
  localparam logic signed [SW-1:0] ONE     = SW'(1);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e     state, state_nxt;
  logic [4:0] k, k_nxt, kcur, blk_len, last_idx;
  logic [5:0] qp_lat, qp_sel;
  mode_e      mode_lat, mode_in, mode_sel;
  logic       stall, in_xfer, err_set;

  logic [3:0] lut_qdiv;
  logic [2:0] unused_qmod;
  logic [4:0] lut_va, lut_vb, lut_vc, v_sel;
  pos_class_e cls;

  logic                 s1_valid, s1_last, s1_dc;
  logic signed [DW-1:0] s1_c;
  logic [4:0]           s1_v;
  logic [3:0]           s1_qdiv, s2_qdiv;
  mode_e                s1_mode, s2_mode;
  logic                 s2_valid, s2_last, s2_dc;
  logic signed [PW-1:0] s2_p;
  logic signed [SW-1:0] ext, sh, res;
  logic signed [OW-1:0] w_sat;

  assign stall    = OUT_VALID && !OUT_READY;
  assign IN_READY = !stall;
  assign in_xfer  = IN_VALID && IN_READY;

  // Reserved mode 3 behaves as AC; SOP coefficients use the live QP/MODE.
  assign mode_in  = (MODE == 2'd3) ? MODE_AC : mode_e'(MODE);
  assign qp_sel   = IN_SOP ? QP : qp_lat;
  assign mode_sel = IN_SOP ? mode_in : mode_lat;

  h264dequant_qp_lut u_qp_lut (
    .qp   (qp_sel),
    .qdiv (lut_qdiv),
    .qmod (unused_qmod),
    .va   (lut_va),
    .vb   (lut_vb),
    .vc   (lut_vc)
  );

  // Block position tracking; out-of-protocol transfers restart at index 0.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    kcur      = 5'd0;
    err_set   = 1'b0;
    blk_len   = (mode_sel == MODE_CDC) ? BLK_LEN_CDC : BLK_LEN_4X4;
    last_idx  = blk_len - 5'd1 - 5'(LASTADVANCE);
    if (!IN_SOP && state == ST_ACTIVE) kcur = k;
    if (in_xfer) begin
      err_set   = (IN_SOP && state == ST_ACTIVE) || (!IN_SOP && state == ST_IDLE);
      state_nxt = (kcur == blk_len - 5'd1) ? ST_IDLE : ST_ACTIVE;
      k_nxt     = kcur + 5'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      k        <= 5'd0;
      qp_lat   <= 6'd0;
      mode_lat <= MODE_AC;
      ERR      <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      ERR   <= ERR | err_set;
      if (in_xfer && IN_SOP) begin
        qp_lat   <= QP;
        mode_lat <= mode_in;
      end
    end
  end

  always_comb begin
    cls = CLS_A;
    if (mode_sel == MODE_AC) cls = ZZ_CLASS[kcur[3:0]];
    case (cls)
      CLS_A:   v_sel = lut_va;
      CLS_B:   v_sel = lut_vb;
      default: v_sel = lut_vc;
    endcase
  end

  // Mode-dependent shift and rounding, kept at full precision until clipping.
  always_comb begin
    ext = SW'(s2_p);
    sh  = ext <<< s2_qdiv;
    case (s2_mode)
      MODE_LDC: begin
        if (s2_qdiv >= 4'd2)      res = sh >>> 2;
        else if (s2_qdiv == 4'd1) res = (ext + ONE) >>> 1;
        else                      res = (ext + (ONE <<< 1)) >>> 2;
      end
      MODE_CDC: res = sh >>> 1;
      default:  res = sh;
    endcase
    w_sat = OW'(res);
    if (SATURATE != 0) begin
      if (res > SAT_MAX)      w_sat = OW'(SAT_MAX);
      else if (res < SAT_MIN) w_sat = OW'(SAT_MIN);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_dc     <= 1'b0;
      s1_c      <= '0;
      s1_v      <= 5'd0;
      s1_qdiv   <= 4'd0;
      s1_mode   <= MODE_AC;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_dc     <= 1'b0;
      s2_p      <= '0;
      s2_qdiv   <= 4'd0;
      s2_mode   <= MODE_AC;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      OUT_DC    <= 1'b0;
      WOUT      <= '0;
    end else if (!stall) begin
      s1_valid  <= in_xfer;
      s1_last   <= in_xfer && (kcur == last_idx);
      s1_dc     <= in_xfer && (mode_sel != MODE_AC);
      s1_c      <= ZIN;
      s1_v      <= v_sel;
      s1_qdiv   <= lut_qdiv;
      s1_mode   <= mode_sel;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_dc     <= s1_dc;
      s2_p      <= PW'(s1_c) * PW'($signed({1'b0, s1_v}));
      s2_qdiv   <= s1_qdiv;
      s2_mode   <= s1_mode;
      OUT_VALID <= s2_valid;
      OUT_LAST  <= s2_last;
      OUT_DC    <= s2_dc;
      WOUT      <= w_sat;
    end
  end

endmodule

// File: tb/tb_h264dequantise_stream.sv
// Directed self-checking bench for h264dequantise_stream with hand-computed expectations.
module tb_h264dequantise_stream;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sop, out_valid, out_ready, out_last, out_dc, err;
  logic [5:0] qp_i;
  logic [1:0] mode_i;
  logic signed [15:0] zin, wout;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  int first_cyc = 0;
  int q_w[$];
  bit q_last[$];
  bit q_dc[$];
  int q_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  h264dequantise_stream dut (
    .CLK       (clk),
    .RESET     (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_SOP    (in_sop),
    .QP        (qp_i),
    .MODE      (mode_i),
    .ZIN       (zin),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_LAST  (out_last),
    .OUT_DC    (out_dc),
    .WOUT      (wout),
    .ERR       (err)
  );

  // Output monitor: records every completed output transfer.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_w.push_back(int'(wout));
      q_last.push_back(out_last);
      q_dc.push_back(out_dc);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    q_w.delete();
    q_last.delete();
    q_dc.delete();
    q_cyc.delete();
  endtask

  task automatic send(input bit sop, input int qp, input int mode, input int z);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_sop   = sop;
    qp_i     = 6'(qp);
    mode_i   = 2'(mode);
    zin      = 16'(z);
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        xfer_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    if (!ok) begin
      nvec++; nfail++;
      $display("FAIL send_timeout: IN_READY low for 64 cycles, required high");
    end
  endtask

  task automatic send_block(input int qp, input int mode, input int n, input int z[16]);
    for (int i = 0; i < n; i++) begin
      send(i == 0, qp, mode, z[i]);
      if (i == 0) first_cyc = xfer_cyc;
    end
  endtask

  task automatic wait_outputs(input int n);
    for (int t = 0; t < 200 && q_w.size() < n; t++) begin
      @(posedge clk); #2;
    end
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; qp_i = '0; mode_i = '0; zin = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nvec++; if (out_last !== 1'b0) begin nfail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    nvec++; if (out_dc !== 1'b0) begin nfail++; $display("FAIL reset_out_dc: got %b want 0", out_dc); end
    nvec++; if (wout !== 16'sd0) begin nfail++; $display("FAIL reset_wout: got %0d want 0", wout); end
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL reset_err: got %b want 0", err); end
    nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_ac();
    int z[16];
    int e[16];
    z = '{default: 0};
    e = '{default: 0};
    z[0] = 3;  e[0] = 768;
    z[1] = 1;  e[1] = 320;
    z[2] = 1;  e[2] = 320;
    z[4] = -2; e[4] = -800;
    z[15] = -1; e[15] = -400;
    clear_q();
    send_block(28, 0, 16, z);
    wait_outputs(16);
    nvec++;
    if (q_w.size() != 16) begin
      nfail++; $display("FAIL ac_count: got %0d outputs want 16", q_w.size());
    end else begin
      nvec++; if (q_cyc[0] - first_cyc != 3) begin nfail++; $display("FAIL ac_latency: got %0d cycles want 3", q_cyc[0] - first_cyc); end
      for (int i = 0; i < 16; i++) begin
        nvec++; if (q_w[i] !== e[i]) begin nfail++; $display("FAIL ac_w[%0d]: got %0d want %0d", i, q_w[i], e[i]); end
        nvec++; if (q_last[i] !== (i == 15)) begin nfail++; $display("FAIL ac_last[%0d]: got %b want %b", i, q_last[i], i == 15); end
        nvec++; if (q_dc[i] !== 1'b0) begin nfail++; $display("FAIL ac_dc[%0d]: got %b want 0", i, q_dc[i]); end
      end
    end
  endtask

  task automatic test_luma_dc();
    int qps[3] = '{0, 6, 18};
    int e0[3]  = '{13, 25, 100};
    int e1[3]  = '{-12, -25, -100};
    int z[16];
    z = '{default: 0};
    z[0] = 5;
    z[1] = -5;
    for (int b = 0; b < 3; b++) begin
      clear_q();
      send_block(qps[b], 1, 16, z);
      wait_outputs(16);
      nvec++;
      if (q_w.size() != 16) begin
        nfail++; $display("FAIL ldc_count qp%0d: got %0d want 16", qps[b], q_w.size());
      end else begin
        nvec++; if (q_w[0] !== e0[b]) begin nfail++; $display("FAIL ldc_w0 qp%0d: got %0d want %0d", qps[b], q_w[0], e0[b]); end
        nvec++; if (q_w[1] !== e1[b]) begin nfail++; $display("FAIL ldc_w1 qp%0d: got %0d want %0d", qps[b], q_w[1], e1[b]); end
        nvec++; if (q_dc[0] !== 1'b1) begin nfail++; $display("FAIL ldc_dc qp%0d: got %b want 1", qps[b], q_dc[0]); end
        nvec++; if (q_last[14] !== 1'b0) begin nfail++; $display("FAIL ldc_last14 qp%0d: got %b want 0", qps[b], q_last[14]); end
        nvec++; if (q_last[15] !== 1'b1) begin nfail++; $display("FAIL ldc_last15 qp%0d: got %b want 1", qps[b], q_last[15]); end
      end
    end
  endtask

  task automatic test_chroma_dc();
    int z[16];
    int e[4] = '{-15, 20, 0, 5};
    z = '{default: 0};
    z[0] = -3; z[1] = 4; z[2] = 0; z[3] = 1;
    clear_q();
    send_block(0, 2, 4, z);
    wait_outputs(4);
    nvec++;
    if (q_w.size() != 4) begin
      nfail++; $display("FAIL cdc_count: got %0d want 4", q_w.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++; if (q_w[i] !== e[i]) begin nfail++; $display("FAIL cdc_w[%0d]: got %0d want %0d", i, q_w[i], e[i]); end
        nvec++; if (q_last[i] !== (i == 3)) begin nfail++; $display("FAIL cdc_last[%0d]: got %b want %b", i, q_last[i], i == 3); end
        nvec++; if (q_dc[i] !== 1'b1) begin nfail++; $display("FAIL cdc_dc[%0d]: got %b want 1", i, q_dc[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int z[16];
    int e[16] = '{256, 640, 960, 1024, 2000, 1536, 2240, 2560,
                  2880, 3200, 4400, 3072, 5200, 4480, 4800, 6400};
    for (int i = 0; i < 16; i++) z[i] = i + 1;
    clear_q();
    fork
      send_block(28, 0, 16, z);
      begin
        repeat (8) @(posedge clk);
        #1; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
        end
        @(posedge clk); #1; out_ready = 1'b1;
      end
    join
    wait_outputs(16);
    nvec++;
    if (q_w.size() != 16) begin
      nfail++; $display("FAIL bp_count: got %0d want 16", q_w.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        nvec++; if (q_w[i] !== e[i]) begin nfail++; $display("FAIL bp_w[%0d]: got %0d want %0d", i, q_w[i], e[i]); end
      end
      nvec++; if (q_last[15] !== 1'b1) begin nfail++; $display("FAIL bp_last: got %b want 1", q_last[15]); end
    end
  endtask

  task automatic test_saturation();
    int qps[2] = '{51, 63};
    int z[16];
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 2; s++) begin
        z = '{default: 0};
        z[0] = (s == 0) ? 1 : -1;
        z[4] = (s == 0) ? 100 : -100;
        clear_q();
        send_block(qps[b], 0, 16, z);
        wait_outputs(16);
        nvec++;
        if (q_w.size() != 16) begin
          nfail++; $display("FAIL sat_count qp%0d: got %0d want 16", qps[b], q_w.size());
        end else begin
          nvec++; if (q_w[0] !== ((s == 0) ? 3584 : -3584)) begin nfail++; $display("FAIL sat_w0 qp%0d: got %0d want %0d", qps[b], q_w[0], (s == 0) ? 3584 : -3584); end
          nvec++; if (q_w[4] !== ((s == 0) ? 32767 : -32768)) begin nfail++; $display("FAIL sat_w4 qp%0d: got %0d want %0d", qps[b], q_w[4], (s == 0) ? 32767 : -32768); end
        end
      end
    end
  endtask

  task automatic test_protocol();
    int nlast;
    clear_q();
    for (int i = 0; i < 7; i++) send(i == 0, 28, 0, 0);
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL proto_err_before: got %b want 0", err); end
    send(1'b1, 28, 0, 1);
    nvec++; if (err !== 1'b1) begin nfail++; $display("FAIL proto_err_after: got %b want 1", err); end
    for (int i = 1; i < 16; i++) send(1'b0, 28, 0, 0);
    wait_outputs(23);
    nvec++;
    if (q_w.size() != 23) begin
      nfail++; $display("FAIL proto_count: got %0d want 23", q_w.size());
    end else begin
      nlast = 0;
      foreach (q_last[i]) if (q_last[i]) nlast++;
      nvec++; if (nlast != 1) begin nfail++; $display("FAIL proto_nlast: got %0d want 1", nlast); end
      nvec++; if (q_last[22] !== 1'b1) begin nfail++; $display("FAIL proto_last22: got %b want 1", q_last[22]); end
      nvec++; if (q_w[7] !== 256) begin nfail++; $display("FAIL proto_w7: got %0d want 256", q_w[7]); end
    end
  endtask

  task automatic test_reset_midblock();
    int z[16];
    int e[4] = '{20, -10, 30, 0};
    for (int i = 0; i < 5; i++) send(i == 0, 28, 0, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL rst_mid_err: got %b want 0", err); end
    z = '{default: 0};
    z[0] = 2; z[1] = -1; z[2] = 3; z[3] = 0;
    send_block(6, 2, 4, z);
    wait_outputs(4);
    nvec++;
    if (q_w.size() != 4) begin
      nfail++; $display("FAIL rst_fresh_count: got %0d want 4", q_w.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++; if (q_w[i] !== e[i]) begin nfail++; $display("FAIL rst_fresh_w[%0d]: got %0d want %0d", i, q_w[i], e[i]); end
      end
      nvec++; if (q_last[3] !== 1'b1) begin nfail++; $display("FAIL rst_fresh_last: got %b want 1", q_last[3]); end
    end
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL rst_fresh_err: got %b want 0", err); end
    // Orphan coefficient after a complete block reuses the latched chroma-DC QP 6.
    clear_q();
    send(1'b0, 0, 0, 2);
    wait_outputs(1);
    nvec++;
    if (q_w.size() != 1) begin
      nfail++; $display("FAIL orphan_count: got %0d want 1", q_w.size());
    end else begin
      nvec++; if (q_w[0] !== 20) begin nfail++; $display("FAIL orphan_w: got %0d want 20", q_w[0]); end
      nvec++; if (q_dc[0] !== 1'b1) begin nfail++; $display("FAIL orphan_dc: got %b want 1", q_dc[0]); end
    end
    nvec++; if (err !== 1'b1) begin nfail++; $display("FAIL orphan_err: got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_ac();
    test_luma_dc();
    test_chroma_dc();
    test_back_to_back();
    test_saturation();
    test_protocol();
    test_reset_midblock();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
